regbank_wr_arbiter: RTL

Write-port controller for the 32×32 register bank (`Registers_Bank`). The block shares the bank's single write port (`addr_d`, `data`, `write`) between two writeback requesters, A (ALU) and B (load/memory), using round-robin arbitration. After every reset it runs a sequencer that zero-fills all registers before accepting any requests. Outputs drive the bank's write port directly; the bank's read ports are untouched.

---
 rtl/regbank_wr_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/regbank_wr_arbiter.sv
// Shared write-port controller for the 32x32 register bank: zero-fills the bank after
// reset, then arbitrates round-robin between writeback requesters A and B.
//
// state | meaning
// ------+------------------------------------------------------------
// INIT  | zero-fill sequencer owns the write port; requests are held off
// RUN   | round-robin arbitration between A and B, one write per cycle
module regbank_wr_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic [ADDR_W-1:0] bank_addr_d,
    output logic [DATA_W-1:0] bank_data,
    output logic              bank_write,
    output logic              init_done
);

    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // One extra bit so the counter can reach NUM_REGS when NUM_REGS == 2^ADDR_W.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_REGS);

    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] clr_cnt;
    logic             last;

    // Grants depend only on valids, state and the round-robin pointer.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (state == RUN) begin
            a_ready = a_valid && (!b_valid || (last == LAST_B));
            b_ready = b_valid && (!a_valid || (last == LAST_A));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= INIT;
            clr_cnt     <= '0;
            last        <= LAST_B;
            bank_write  <= 1'b0;
            bank_addr_d <= '0;
            bank_data   <= '0;
            init_done   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (clr_cnt == CNT_LAST) begin
                        state      <= RUN;
                        init_done  <= 1'b1;
                        bank_write <= 1'b0;
                    end else begin
                        bank_write  <= 1'b1;
                        bank_addr_d <= clr_cnt[ADDR_W-1:0];
                        bank_data   <= '0;
                        clr_cnt     <= clr_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (a_ready) begin
                        bank_write  <= 1'b1;
                        bank_addr_d <= a_addr;
                        bank_data   <= a_data;
                        last        <= LAST_A;
                    end else if (b_ready) begin
                        bank_write  <= 1'b1;
                        bank_addr_d <= b_addr;
                        bank_data   <= b_data;
                        last        <= LAST_B;
                    end else begin
                        bank_write <= 1'b0;
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule
